// File: rtl/seg7x4_pkg.sv
// +----------------------------------------------------------------------+
// | Module : seg7x4_pkg                                                  |
// | Brief  : Shared types and segment patterns for the 4-digit 7-segment |
// |          scan controller.                                            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package seg7x4_pkg;

  // Scan FSM: all segments dark between slots, then one digit lit.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Active-high segment patterns, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

`default_nettype wire

// File: rtl/seg7_bcd_decode.sv
// +----------------------------------------------------------------------+
// | Module : seg7_bcd_decode                                             |
// | Brief  : Combinational BCD to 7-segment decoder. Non-decimal codes   |
// |          produce a dark digit.                                       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module seg7_bcd_decode
  import seg7x4_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup; codes 0xA..0xF leave the digit dark.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7x4_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | Module : seg7x4_scan_ctrl                                            |
// | Brief  : Time-multiplexed scan of 4 BCD digits onto one 7-bit        |
// |          segment bus, with blanking gaps between slots and a         |
// |          frame-synchronous double buffer for the digit values.       |
// | Config : SEGX4_PWM_DIM_EN adds the 3-bit brightness input, which     |
// |          shortens the lit part of each SHOW slot.                    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module seg7x4_scan_ctrl
  import seg7x4_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic        load,
  output logic [6:0]  seg_out,
  output logic [1:0]  dig_sel,
  output logic        dig_en,
  output logic        frame_done
`ifdef SEGX4_PWM_DIM_EN
  ,
  input  logic [2:0]  brightness
`endif
);

  localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

  scan_state_e   state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [1:0]    idx, idx_nx;
  logic          wrap;
  logic          wrap_q;
  logic [15:0]   pending;
  logic [15:0]   shadow;
  logic [3:0]    cur_digit;
  logic [6:0]    seg_dec;
  logic          lit;

  // Scan state register: FSM state, slot timer and digit index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= BLANK;
      timer <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state logic; wrap flags the SHOW(idx3) -> BLANK(idx0) frame boundary.
  always_comb begin
    state_nx = state;
    timer_nx = timer + 1'b1;
    idx_nx   = idx;
    wrap     = 1'b0;
    case (state)
      BLANK: begin
        if (timer == BLANK_LAST) begin
          state_nx = SHOW;
          timer_nx = '0;
        end
      end
      SHOW: begin
        if (timer == DWELL_LAST) begin
          state_nx = BLANK;
          timer_nx = '0;
          idx_nx   = idx + 1'b1;
          wrap     = (idx == 2'd3);
        end
      end
      default: begin
        state_nx = BLANK;
        timer_nx = '0;
      end
    endcase
  end

  // Double buffer: loads land in pending; shadow only moves at the frame boundary,
  // taking a coincident load directly so it is not delayed by a whole frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
      shadow  <= '0;
    end else begin
      if (load) pending <= digits_in;
      if (wrap) shadow <= load ? digits_in : pending;
    end
  end

  assign cur_digit = shadow[{idx, 2'b00} +: 4];

  seg7_bcd_decode u_decode (
    .bcd (cur_digit),
    .seg (seg_dec)
  );

`ifdef SEGX4_PWM_DIM_EN
  logic [31:0] on_limit;
  // Lit window: first (brightness+1)/8 of the dwell, then dark for the rest of the slot.
  always_comb begin
    on_limit = (({29'd0, brightness} + 32'd1) * 32'(DWELL_CYCLES)) / 32'd8;
    lit      = ({{(32-TW){1'b0}}, timer} < on_limit);
  end
`else
  assign lit = 1'b1;
`endif

  // Output register: everything follows the scan state one cycle later, so
  // dig_sel, dig_en and frame_done all move on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_out    <= SEG_BLANK;
      dig_sel    <= 2'd0;
      dig_en     <= 1'b0;
      wrap_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= ((state == SHOW) && lit) ? seg_dec : SEG_BLANK;
      dig_en     <= (state == SHOW) && lit;
      dig_sel    <= idx;
      wrap_q     <= wrap;
      frame_done <= wrap_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7x4_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | Module : tb_seg7x4_scan_ctrl                                         |
// | Brief  : Self-checking bench for seg7x4_scan_ctrl (DWELL=8, BLANK=2) |
// |          against a time-based reference model. Honours               |
// |          SEGX4_PWM_DIM_EN when defined.                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_seg7x4_scan_ctrl;

  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int SLOT  = DWELL + BLANK;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic        load;
  logic [6:0]  seg_out;
  logic [1:0]  dig_sel;
  logic        dig_en;
  logic        frame_done;
`ifdef SEGX4_PWM_DIM_EN
  logic [2:0]  brightness;
`endif

  always #5 clk = ~clk;

  seg7x4_scan_ctrl #(
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .load       (load),
    .seg_out    (seg_out),
    .dig_sel    (dig_sel),
    .dig_en     (dig_en),
    .frame_done (frame_done)
`ifdef SEGX4_PWM_DIM_EN
    ,
    .brightness (brightness)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time since reset decides slot and phase; digit values
  // are the last value loaded at or before the edge that starts the frame.
  int          st;
  int          out_t;
  logic [15:0] last_loaded;
  logic [15:0] frame_val;
  logic [15:0] out_val;
  logic [6:0]  seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare all outputs.
  task automatic cycle(input string tag, input logic r, input logic ld, input logic [15:0] d);
    logic [6:0] e_seg;
    logic [1:0] e_sel;
    logic       e_en;
    logic       e_fd;
    int         off;
    int         lit_len;
    int         di;
    logic [3:0] nib;
    rst       = r;
    load      = ld;
    digits_in = d;
    lit_len   = DWELL;
`ifdef SEGX4_PWM_DIM_EN
    lit_len   = ((int'(brightness) + 1) * DWELL) / 8;
`endif
    @(posedge clk);
    if (!r) begin
      out_t       = -1;
      st          = 0;
      last_loaded = '0;
      frame_val   = '0;
    end else begin
      out_t   = st;
      out_val = frame_val;
      st++;
      if (ld) last_loaded = d;
      if (st % FRAME == 0) frame_val = last_loaded;
    end
    e_seg = 7'd0;
    e_sel = 2'd0;
    e_en  = 1'b0;
    e_fd  = 1'b0;
    if (out_t >= 0) begin
      off   = out_t % SLOT;
      di    = (out_t / SLOT) % 4;
      e_sel = 2'(di);
      e_fd  = (out_t > 0) && (out_t % FRAME == 0);
      if (off >= BLANK && (off - BLANK) < lit_len) begin
        e_en = 1'b1;
        nib  = out_val[di*4 +: 4];
        e_seg = (nib < 4'd10) ? seg_tab[nib] : 7'd0;
      end
    end
    #1;
    check_value(tag, {21'd0, frame_done, dig_en, dig_sel, seg_out},
                     {21'd0, e_fd, e_en, e_sel, e_seg});
  endtask

  initial begin
    int first_en;
    rst       = 1'b0;
    load      = 1'b0;
    digits_in = 16'h0;
    out_t     = -1;
    st        = 0;
    last_loaded = '0;
    frame_val = '0;
    out_val   = '0;
`ifdef SEGX4_PWM_DIM_EN
    brightness = 3'd7;
`endif

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) cycle("reset", 1'b0, 1'b0, 16'h0);

    // Release and locate the first lit edge; load 1234 during frame 0.
    first_en = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle("release", 1'b1, (i == 5), (i == 5) ? 16'h1234 : 16'h0);
      if (dig_en && first_en == 0) first_en = i;
    end
    check_value("first_show_edge", 32'(first_en), 32'd3);

    // Two frames showing 1234.
    for (int i = 0; i < 80; i++) cycle("frame1234", 1'b1, 1'b0, 16'h0);

    // Move into the idx1 SHOW slot and load 5678 there (no tearing expected).
    for (int i = 0; i < FRAME && (st % FRAME) != 14; i++) cycle("seek1", 1'b1, 1'b0, 16'h0);
    cycle("load5678", 1'b1, 1'b1, 16'h5678);
    for (int i = 0; i < 80; i++) cycle("tear5678", 1'b1, 1'b0, 16'h0);

    // Non-decimal code on digit0.
    cycle("load000A", 1'b1, 1'b1, 16'h000A);
    for (int i = 0; i < 90; i++) cycle("code_A", 1'b1, 1'b0, 16'h0);

    // Reset pulse mid-SHOW of idx2: shadow is cleared, digits show 0.
    for (int i = 0; i < FRAME && (st % FRAME) != 24; i++) cycle("seek2", 1'b1, 1'b0, 16'h0);
    cycle("midrst", 1'b0, 1'b0, 16'h0);
    check_value("midrst_idle", {29'd0, dig_en, dig_sel}, 32'd0);
    for (int i = 0; i < 100; i++) cycle("after_rst", 1'b1, 1'b0, 16'h0);

`ifdef SEGX4_PWM_DIM_EN
    brightness = 3'd3;
    for (int i = 0; i < 80; i++) cycle("dim3", 1'b1, 1'b0, 16'h0);
    brightness = 3'd7;
`endif

    // Randomized loads, digit codes and occasional resets.
    for (int i = 0; i < 1500; i++) begin
`ifdef SEGX4_PWM_DIM_EN
      if (i % 50 == 0) brightness = 3'($urandom_range(0, 7));
`endif
      cycle("random", ($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
